// File: rtl/rsp_pkg.sv
// Shared definitions for the adrv9009_rsp input path: scheduler states,
// default sample width and signed saturation limits.
package rsp_pkg;

  localparam int DW_DEF = 16;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GAP   = 3'd1,
    SRC_A = 3'd2,
    SRC_B = 3'd3,
    MIX   = 3'd4
  } sched_state_e;

endpackage

// File: rtl/rsp_sat_add.sv
// Combinational DW-bit signed saturating adder. Overflow shows up as the two
// top bits of the (DW+1)-bit sum disagreeing.
module rsp_sat_add #(
  parameter int DW = rsp_pkg::DW_DEF
) (
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] y
);

  logic signed [DW:0] sum;

  always_comb begin
    sum = {a[DW-1], a} + {b[DW-1], b};
    if (sum[DW] != sum[DW-1])
      y = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      y = sum[DW-1:0];
  end

endmodule

// File: rtl/rsp_src_sched.sv
// Fixed-schedule input arbiter for the RSP: zero gap, A only, B only, then a
// saturating A+B mix until stopped. Phase lengths are in clock cycles.
module rsp_src_sched
  import rsp_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int CW      = 13,
  parameter int GAP_LEN = 15,
  parameter int A_LEN   = 285,
  parameter int B_LEN   = 300
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [DW-1:0] a_data,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [DW-1:0] b_data,
  input  logic          b_valid,
  output logic          b_ready,
  output logic [DW-1:0] out,
  output logic          out_valid,
  output logic [2:0]    phase,
  output logic [7:0]    underrun
);

  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_LEN - 1);
  localparam logic [CW-1:0] A_LAST   = CW'(A_LEN - 1);
  localparam logic [CW-1:0] B_LAST   = CW'(B_LEN - 1);

  sched_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    underrun_q, underrun_d;
  logic          und_inc;
  logic          both_valid;
  logic [DW-1:0] mix_sum;

  rsp_sat_add #(.DW(DW)) u_sat_add (
    .a (a_data),
    .b (b_data),
    .y (mix_sum)
  );

  assign both_valid = a_valid & b_valid;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    out_d       = out_q;
    out_valid_d = 1'b0;
    underrun_d  = underrun_q;
    und_inc     = 1'b0;
    a_ready     = 1'b0;
    b_ready     = 1'b0;

    case (state_q)
      IDLE: begin
        out_d = '0;
        cnt_d = '0;
        if (start) begin
          state_d    = GAP;
          underrun_d = '0;
        end
      end
      GAP: begin
        out_d       = '0;
        out_valid_d = 1'b1;
        if (cnt_q == GAP_LAST) begin
          state_d = SRC_A;
          cnt_d   = '0;
        end
      end
      SRC_A: begin
        a_ready = 1'b1;
        if (a_valid) begin
          out_d       = a_data;
          out_valid_d = 1'b1;
        end else begin
          und_inc = 1'b1;
        end
        if (cnt_q == A_LAST) begin
          state_d = SRC_B;
          cnt_d   = '0;
        end
      end
      SRC_B: begin
        b_ready = 1'b1;
        if (b_valid) begin
          out_d       = b_data;
          out_valid_d = 1'b1;
        end else begin
          und_inc = 1'b1;
        end
        if (cnt_q == B_LAST) begin
          state_d = MIX;
          cnt_d   = '0;
        end
      end
      MIX: begin
        // Consume both sources together so A and B stay sample-aligned.
        a_ready = both_valid;
        b_ready = both_valid;
        cnt_d   = '0;
        if (both_valid) begin
          out_d       = mix_sum;
          out_valid_d = 1'b1;
        end else begin
          und_inc = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        out_d   = '0;
      end
    endcase

    if (und_inc && underrun_q != 8'hFF)
      underrun_d = underrun_q + 8'd1;

    // Stop outranks start and phase expiry.
    if (stop) begin
      state_d     = IDLE;
      cnt_d       = '0;
      out_d       = '0;
      out_valid_d = 1'b0;
      underrun_d  = underrun_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      underrun_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign phase     = state_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_rsp_src_sched.sv
// Directed bench for rsp_src_sched: full schedule run, table of MIX vectors,
// then hand-written underrun, reset, stop and stray-start sequences.
module tb_rsp_src_sched;
  import rsp_pkg::*;

  logic               clk = 1'b0;
  logic               reset, start, stop;
  logic signed [15:0] a_data, b_data;
  logic               a_valid, b_valid;
  logic               a_ready, b_ready;
  logic signed [15:0] out_s;
  logic               out_valid;
  logic [2:0]         phase;
  logic [7:0]         underrun;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int   a;
    int   b;
    logic av;
    logic bv;
    logic ar;
    logic br;
    int   out;
    logic ov;
    int   inc;
  } vec_t;

  vec_t vecs[10];

  rsp_src_sched dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .a_data    (a_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b_data    (b_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .out       (out_s),
    .out_valid (out_valid),
    .phase     (phase),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sched_val(input int k);
    if (k <= 15)       return 0;
    else if (k <= 300) return 100;
    else if (k <= 600) return -50;
    else               return 50;
  endfunction

  function automatic int sched_phase(input int k);
    if (k <= 14)       return 1;
    else if (k <= 299) return 2;
    else if (k <= 599) return 3;
    else               return 4;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int und_exp;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    a_data = '0; b_data = '0; a_valid = 1'b0; b_valid = 1'b0;

    vecs[0] = '{23170, 32767, 1'b1, 1'b1, 1'b1, 1'b1, 32767, 1'b1, 0};
    vecs[1] = '{-23170, -32768, 1'b1, 1'b1, 1'b1, 1'b1, -32768, 1'b1, 0};
    vecs[2] = '{16000, 16000, 1'b1, 1'b1, 1'b1, 1'b1, 32000, 1'b1, 0};
    vecs[3] = '{-1, -1, 1'b1, 1'b1, 1'b1, 1'b1, -2, 1'b1, 0};
    vecs[4] = '{32767, -32768, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b1, 0};
    vecs[5] = '{5, 7, 1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1};
    vecs[6] = '{5, 7, 1'b0, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1};
    vecs[7] = '{5, 7, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1};
    vecs[8] = '{-32768, -1, 1'b1, 1'b1, 1'b1, 1'b1, -32768, 1'b1, 0};
    vecs[9] = '{16384, 16384, 1'b1, 1'b1, 1'b1, 1'b1, 32767, 1'b1, 0};

    tick();
    tick();
    reset = 1'b0;
    check("reset out", int'(out_s), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset phase", int'(phase), 0);
    check("reset underrun", int'(underrun), 0);
    check("reset a_ready", int'(a_ready), 0);
    check("reset b_ready", int'(b_ready), 0);

    // Full schedule with both sources always valid.
    a_data = 16'sd100; b_data = -16'sd50; a_valid = 1'b1; b_valid = 1'b1;
    pulse_start();
    check("start phase", int'(phase), 1);
    check("start out_valid", int'(out_valid), 0);
    for (int k = 1; k <= 620; k++) begin
      tick();
      check("sched out_valid", int'(out_valid), 1);
      check("sched out", int'(out_s), sched_val(k));
      if (k == 14 || k == 15 || k == 299 || k == 300 || k == 599 || k == 600)
        check("sched phase", int'(phase), sched_phase(k));
    end
    check("sched underrun", int'(underrun), 0);

    // MIX vector table.
    und_exp = 0;
    foreach (vecs[i]) begin
      a_data = 16'(vecs[i].a); b_data = 16'(vecs[i].b);
      a_valid = vecs[i].av;    b_valid = vecs[i].bv;
      #1;
      check("vec a_ready", int'(a_ready), int'(vecs[i].ar));
      check("vec b_ready", int'(b_ready), int'(vecs[i].br));
      tick();
      und_exp += vecs[i].inc;
      check("vec out_valid", int'(out_valid), int'(vecs[i].ov));
      check("vec out", int'(out_s), vecs[i].out);
      check("vec underrun", int'(underrun), und_exp);
    end

    // Starve B in MIX long enough to saturate the underrun counter.
    a_data = 16'sd1; b_data = 16'sd2; a_valid = 1'b1; b_valid = 1'b0;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (k == 0 || k == 299) check("starve a_ready", int'(a_ready), 0);
      tick();
    end
    check("sat underrun", int'(underrun), 255);
    check("sat out hold", int'(out_s), 32767);
    check("sat out_valid", int'(out_valid), 0);
    check("sat phase", int'(phase), 4);

    // Reset mid-MIX with busy inputs.
    a_valid = 1'b1; b_valid = 1'b1; start = 1'b1;
    reset = 1'b1;
    tick();
    check("midrst out", int'(out_s), 0);
    check("midrst out_valid", int'(out_valid), 0);
    check("midrst phase", int'(phase), 0);
    check("midrst underrun", int'(underrun), 0);
    tick();
    reset = 1'b0; start = 1'b0;

    // Drop a_valid for three cycles inside SRC_A.
    a_data = 16'sd100; b_data = -16'sd50;
    pulse_start();
    for (int k = 1; k <= 19; k++) tick();
    check("drop pre phase", int'(phase), 2);
    check("drop pre out", int'(out_s), 100);
    a_valid = 1'b0; a_data = 16'sd999;
    for (int k = 20; k <= 22; k++) begin
      tick();
      check("drop out_valid", int'(out_valid), 0);
      check("drop out hold", int'(out_s), 100);
    end
    a_valid = 1'b1; a_data = 16'sd100;
    tick();
    check("drop resume valid", int'(out_valid), 1);
    check("drop underrun", int'(underrun), 3);
    for (int k = 24; k <= 299; k++) tick();
    check("drop srca last", int'(phase), 2);
    tick();
    check("drop srcb first", int'(phase), 3);
    check("drop underrun end", int'(underrun), 3);

    // Stop during GAP cycle 5, then stop+start together in IDLE.
    do_reset();
    pulse_start();
    for (int k = 1; k <= 4; k++) tick();
    check("gap phase", int'(phase), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop phase", int'(phase), 0);
    check("stop out_valid", int'(out_valid), 0);
    check("stop out", int'(out_s), 0);
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    check("stop+start phase", int'(phase), 0);
    tick();
    check("stop+start hold", int'(phase), 0);

    // A stray start in SRC_B must not disturb the sequence.
    pulse_start();
    for (int k = 1; k <= 349; k++) tick();
    check("srcb phase", int'(phase), 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("srcb start phase", int'(phase), 3);
    check("srcb out", int'(out_s), -50);
    for (int k = 351; k <= 599; k++) tick();
    check("srcb last", int'(phase), 3);
    tick();
    check("mix first", int'(phase), 4);
    tick();
    check("mix out", int'(out_s), 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rsp_src_sched.md
# rsp_src_sched

Input scheduler for the `adrv9009_rsp` receive signal path. It arbitrates two 16-bit signed sample sources (tone generators, capture replay) onto the single RSP input. It runs a fixed phase schedule: zero-fill gap, source A only, source B only, then saturating A+B mix until stopped. It sits directly in front of `adrv9009_rsp` and replaces ad-hoc input muxing, so every RSP run sees the same repeatable stimulus sequence.

## Interface
Parameters:
- `DW`, 16, sample width (signed, two's complement)
- `CW`, 13, phase counter width
- `GAP_LEN`, 15, cycles of zero-fill after start
- `A_LEN`, 285, cycles of source-A-only phase
- `B_LEN`, 300, cycles of source-B-only phase

Ports:
- `clk`  in  1  single system clock; all logic rising-edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins schedule from IDLE, ignored elsewhere
- `stop`  in  1  one-cycle pulse; aborts to IDLE from any state
- `a_data`  in  DW  source A sample
- `a_valid`  in  1  source A sample present
- `a_ready`  out  1  source A sample consumed this cycle
- `b_data`  in  DW  source B sample
- `b_valid`  in  1  source B sample present
- `b_ready`  out  1  source B sample consumed this cycle
- `out`  out  DW  sample to RSP `in`, registered
- `out_valid`  out  1  `out` updated this cycle
- `phase`  out  3  current state encoding
- `underrun`  out  8  saturating count of cycles a needed source was not valid

## Operation
- States: IDLE(0), GAP(1), SRC_A(2), SRC_B(3), MIX(4).
- IDLE: `out` = 0, `out_valid` = 0, readies low. `start` → GAP, counter cleared, `underrun` cleared.
- GAP: `out` = 0, `out_valid` = 1 every cycle. Sources are not consumed. After GAP_LEN cycles → SRC_A.
- SRC_A: `a_ready` = 1. If `a_valid`, then `out` ← `a_data` and `out_valid` = 1. Otherwise `out` holds its value, `out_valid` = 0, and `underrun` increments. After A_LEN cycles → SRC_B.
- SRC_B: same behaviour with source B, lasting B_LEN cycles → MIX.
- MIX: `a_ready` = `b_ready` = `a_valid & b_valid`, so both sources are consumed together or neither is.
  - Both valid: `out` ← sat(`a_data` + `b_data`).
  - Otherwise: hold `out`, `out_valid` = 0, `underrun` increments.
  - MIX has no length limit.
- Saturating add: compute the (DW+1)-bit sum. Results above 32767 clamp to 32767; results below −32768 clamp to −32768.
- Phase counter (CW bits) counts clock cycles, not accepted samples. Lengths are exact. Counter clears on every state change.
- `stop` has priority over `start` and over phase expiry. Next state is IDLE, with `out` = 0 and `out_valid` = 0.
- `underrun` saturates at 255 and does not wrap.

## Timing
- Reset values: `out` = 0, `out_valid` = 0, `a_ready` = `b_ready` = 0, `phase` = 0 (IDLE), `underrun` = 0.
- `a_ready` / `b_ready` are combinational from state and valids. A handshake completes in the cycle ready&valid is high.
- `out` / `out_valid` are registered and appear 1 cycle after the handshake.
- `start` at edge n gives `phase` = GAP from cycle n+1. The first GAP `out_valid` appears at n+2.
- The transition occurs on the edge ending the last cycle of each phase (GAP_LEN, A_LEN, B_LEN exactly).
- `stop` and `start` in the same cycle while IDLE: remain IDLE.
- Reset mid-operation returns to the reset values on the next edge, regardless of other inputs.

## Structure
- Shared package `rsp_pkg` holds:
  - the state enum encoding (IDLE..MIX)
  - the `DW` default
  - the saturation limit constants `SAT_MAX` = 32767 and `SAT_MIN` = −32768
- One sub-module: `rsp_sat_add` (combinational DW-bit signed saturating adder), reusable elsewhere in the RSP.
- The FSM, counter and underrun logic stay in the top.

## Test plan
- Reset held 2 cycles mid-MIX → next edge: `out` = 0, `out_valid` = 0, `phase` = 0, `underrun` = 0.
- `start` with `a_valid` = `b_valid` = 1 held constantly, `a_data` = 100, `b_data` = −50:
  - 15 outputs of 0
  - then 285 outputs of 100
  - then 300 outputs of −50
  - then continuous 50
  - `underrun` = 0
- MIX with `a_data` = 23170, `b_data` = 32767 → `out` = 32767. With `a_data` = −23170, `b_data` = −32768 → `out` = −32768.
- In SRC_A, drop `a_valid` for 3 cycles:
  - `out_valid` low for exactly those 3 cycles
  - `out` holds its last value
  - `underrun` = 3
  - SRC_A still ends after 285 cycles total
- In MIX with `a_valid` = 1, `b_valid` = 0: `a_ready` = 0, no sample consumed. Then hold the condition for 300 cycles → `underrun` saturates at 255.
- `stop` at GAP cycle 5 → IDLE next edge, `out_valid` = 0. A `start` pulse issued during SRC_B has no effect on the phase sequence.
